// File: rtl/direction_cmd_sched.sv
// Frame-rate command scheduler: debounces per-frame direction codes, enforces a
// cooldown after each confirmed command and queues commands for a valid/ready consumer.
module direction_cmd_sched #(
  parameter int STABLE_FRAMES   = 3,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iEnable,
  input  logic       iFrameEnd,
  input  logic [2:0] iDirection,
  output logic       oCmdValid,
  output logic [2:0] oCmd,
  input  logic       iCmdReady,
  output logic [4:0] oLevel,
  output logic [1:0] oState,
  output logic [7:0] oDropCount
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t        state, stateNext;
  logic [2:0]    cand, candNext;
  logic [3:0]    cnt, cntNext;
  logic [7:0]    cool, coolNext;
  logic          confirm;
  logic [2:0]    pushCode;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [4:0]    level;
  logic [7:0]    dropCount;
  logic          full, pop, wrEn;

  // Handshake: the head entry transfers on any cycle where oCmdValid and iCmdReady
  // are both high; oCmd/oCmdValid hold steady while valid is high and ready is low.

  // Debounce / cooldown datapath; confirmation clears cand/cnt and loads cool.
  always_comb begin
    candNext = cand;
    cntNext  = cnt;
    coolNext = cool;
    confirm  = 1'b0;
    pushCode = 3'd7;
    if (!iEnable || state == IDLE) begin
      candNext = 3'd7;
      cntNext  = 4'd0;
      coolNext = 8'd0;
    end else if (state == TRACK && iFrameEnd) begin
      if (iDirection == 3'd7) begin
        candNext = 3'd7;
        cntNext  = 4'd0;
      end else if (iDirection == cand) begin
        cntNext = cnt + 4'd1;
      end else begin
        candNext = iDirection;
        cntNext  = 4'd1;
      end
      if (cntNext == STABLE_FRAMES[3:0]) begin
        confirm  = 1'b1;
        pushCode = candNext;
        candNext = 3'd7;
        cntNext  = 4'd0;
        coolNext = COOLDOWN_FRAMES[7:0];
      end
    end else if (state == COOLDOWN && iFrameEnd) begin
      coolNext = cool - 8'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cand <= 3'd7;
      cnt  <= 4'd0;
      cool <= 8'd0;
    end else begin
      cand <= candNext;
      cnt  <= cntNext;
      cool <= coolNext;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (!iEnable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:     stateNext = TRACK;
        TRACK:    if (confirm) stateNext = COOLDOWN;
        COOLDOWN: if (iFrameEnd && cool <= 8'd1) stateNext = TRACK;
        default:  stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    oState = state;
  end

  // A push into a full queue survives only when the head leaves in the same cycle.
  assign full      = (level == FIFO_DEPTH[4:0]);
  assign oCmdValid = (level != 5'd0);
  assign pop       = oCmdValid & iCmdReady;
  assign wrEn      = confirm & (!full | pop);
  assign oCmd      = oCmdValid ? mem[rdPtr] : 3'd7;
  assign oLevel    = level;
  assign oDropCount = dropCount;

  always_ff @(posedge iCLK) begin
    if (wrEn) mem[wrPtr] <= pushCode;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      level     <= 5'd0;
      dropCount <= 8'd0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({wrEn, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (confirm && !wrEn && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
    end
  end

endmodule
